copy_arbiter: RTL and testbench

Clocked two-input round-robin merge that shares one 4-phase bundled-data output channel between two requester channels. It is the inverse of the PE fork stage: where the fork duplicates one packet to two consumers, this block serialises packets from two producers (e.g. two copy branches returning to a shared PE port) onto one consumer. It latches the winning packet, completes the full output handshake, then acknowledges the winner. Fairness is strict alternation whenever both inputs request.

---
 rtl/pe_pkg.sv | 14 +
 rtl/copy_arbiter.sv | 107 ++++++++++
 tb/tb_copy_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE copy/merge stages.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OUT_REQ = 2'd1,
        OUT_REL = 2'd2,
        IN_ACK  = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/copy_arbiter.sv
// Two-input round-robin merge onto one 4-phase bundled-data channel.
// The winning packet is latched, the output handshake completes, then the winner is acknowledged.
module copy_arbiter
    import pe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             L0_req,
    input  logic [WIDTH-1:0] L0_data,
    output logic             L0_ack,
    input  logic             L1_req,
    input  logic [WIDTH-1:0] L1_data,
    output logic             L1_ack,
    output logic             R_req,
    output logic [WIDTH-1:0] R_data,
    output logic             R_src,
    input  logic             R_ack,
    output logic [CNT_W-1:0] xfer_cnt
);

    arb_state_t       state_q;
    logic             r_req_q;
    logic [WIDTH-1:0] r_data_q;
    logic             r_src_q;
    logic             l0_ack_q;
    logic             l1_ack_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rr_ptr_q;

    logic             grant_any;
    logic             grant_sel_d;
    logic             src_req;
    logic [CNT_W-1:0] cnt_d;
    logic             rr_ptr_d;

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        grant_any   = L0_req | L1_req;
        grant_sel_d = (L0_req & L1_req) ? rr_ptr_q : L1_req;
        src_req     = r_src_q ? L1_req : L0_req;
        cnt_d       = cnt_q + CNT_W'(1);
        rr_ptr_d    = ~r_src_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            r_req_q  <= 1'b0;
            r_data_q <= '0;
            r_src_q  <= 1'b0;
            l0_ack_q <= 1'b0;
            l1_ack_q <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        r_data_q <= grant_sel_d ? L1_data : L0_data;
                        r_src_q  <= grant_sel_d;
                        r_req_q  <= 1'b1;
                        state_q  <= OUT_REQ;
                    end
                end
                OUT_REQ: begin
                    if (R_ack) begin
                        r_req_q <= 1'b0;
                        state_q <= OUT_REL;
                    end
                end
                OUT_REL: begin
                    if (!R_ack) begin
                        l0_ack_q <= ~r_src_q;
                        l1_ack_q <= r_src_q;
                        state_q  <= IN_ACK;
                    end
                end
                IN_ACK: begin
                    // Always pass through IDLE so a fresh req gets a clean arbitration edge.
                    if (!src_req) begin
                        l0_ack_q <= 1'b0;
                        l1_ack_q <= 1'b0;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= cnt_d;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign R_req    = r_req_q;
    assign R_data   = r_data_q;
    assign R_src    = r_src_q;
    assign L0_ack   = l0_ack_q;
    assign L1_ack   = l1_ack_q;
    assign xfer_cnt = cnt_q;

    // Consumer must not acknowledge while no output request can be outstanding.
    a_no_stray_ack : assert property (@(posedge clk) disable iff (rst)
        !(R_ack && (state_q == IDLE || state_q == IN_ACK)));

endmodule

// File: tb/tb_copy_arbiter.sv
// Scoreboard bench for copy_arbiter: producers/consumer model the 4-phase environment.
module tb_copy_arbiter;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0] data;
        logic         src;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          L0_req, L1_req;
    logic [W-1:0]  L0_data, L1_data;
    logic          L0_ack, L1_ack;
    logic          R_req;
    logic [W-1:0]  R_data;
    logic          R_src;
    logic          R_ack;
    logic [CW-1:0] xfer_cnt;

    int errors = 0;
    int checks = 0;
    int ack_dly = 0;

    pkt_t         sb_q[$];
    logic [W-1:0] p0_q[$];
    logic [W-1:0] p1_q[$];

    copy_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .L0_req  (L0_req),
        .L0_data (L0_data),
        .L0_ack  (L0_ack),
        .L1_req  (L1_req),
        .L1_data (L1_data),
        .L1_ack  (L1_ack),
        .R_req   (R_req),
        .R_data  (R_data),
        .R_src   (R_src),
        .R_ack   (R_ack),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Producer: holds req (across a reset too) until acked, then releases.
    task automatic producer(input bit idx);
        int n;
        forever begin
            @(negedge clk);
            if (!rst && (idx ? p1_q.size() : p0_q.size()) > 0) begin
                if (idx) begin L1_data = p1_q[0]; L1_req = 1'b1; end
                else     begin L0_data = p0_q[0]; L0_req = 1'b1; end
                n = 0;
                while (!(idx ? L1_ack : L0_ack) && n < 300) begin @(negedge clk); n++; end
                checks++;
                if (n >= 300) begin
                    errors++;
                    $display("FAIL producer%0d_ack_timeout: ack=0 after %0d cycles, required 1", idx, n);
                end
                if (idx) begin L1_req = 1'b0; void'(p1_q.pop_front()); end
                else     begin L0_req = 1'b0; void'(p0_q.pop_front()); end
                n = 0;
                while ((idx ? L1_ack : L0_ack) && n < 300) begin @(negedge clk); n++; end
            end
        end
    endtask

    initial producer(1'b0);
    initial producer(1'b1);

    // Consumer: optional ack delay per phase, checks stability and scoreboard order.
    initial begin
        pkt_t cur, exp_p;
        bit   aborted;
        int   n;
        R_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (R_req && !R_ack && !rst) begin
                cur.data = R_data;
                cur.src  = R_src;
                aborted  = 1'b0;
                for (int i = 0; i < ack_dly && !aborted; i++) begin
                    @(posedge clk); #1;
                    if (!R_req) begin
                        aborted = 1'b1;
                        checks++;
                        if (!rst) begin
                            errors++;
                            $display("FAIL r_req_dropped: R_req=0 before ack, required 1");
                        end
                    end else begin
                        checks++;
                        if (R_data !== cur.data || R_src !== cur.src) begin
                            errors++;
                            $display("FAIL r_stable: data=%h src=%0d, required data=%h src=%0d",
                                     R_data, R_src, cur.data, cur.src);
                        end
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_xfer: data=%h src=%0d, required none", R_data, R_src);
                    end else begin
                        exp_p = sb_q.pop_front();
                        if (R_data !== exp_p.data || R_src !== exp_p.src) begin
                            errors++;
                            $display("FAIL xfer: data=%h src=%0d, required data=%h src=%0d",
                                     R_data, R_src, exp_p.data, exp_p.src);
                        end
                    end
                    $display("xfer data=%h src=%0d cnt=%0d", R_data, R_src, xfer_cnt);
                    R_ack = 1'b1;
                    n = 0;
                    while (R_req && n < 300) begin @(posedge clk); #1; n++; end
                    for (int i = 0; i < ack_dly; i++) begin @(posedge clk); #1; end
                    R_ack = 1'b0;
                end
            end
        end
    end

    // Ack invariants: one-hot, to the current source, never during the output handshake.
    always @(negedge clk) begin
        if (!rst && (L0_ack || L1_ack)) begin
            checks++;
            if ((L0_ack && L1_ack) || R_req || R_ack || (L1_ack !== R_src)) begin
                errors++;
                $display("FAIL ack_rule: L0_ack=%0d L1_ack=%0d R_req=%0d R_ack=%0d R_src=%0d, required single ack to src with R_req=R_ack=0",
                         L0_ack, L1_ack, R_req, R_ack, R_src);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 2000 && !(p0_q.size() == 0 && p1_q.size() == 0 && sb_q.size() == 0 &&
               !R_req && !R_ack && !L0_ack && !L1_ack && !L0_req && !L1_req)) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_idle_timeout: pending=%0d, required 0", name, sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_cnt(input string name, input int exp_cnt);
        checks++;
        if (xfer_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL %s_cnt: xfer_cnt=%0d, required %0d", name, xfer_cnt, CW'(exp_cnt));
        end
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (R_req !== 1'b0 || R_data !== '0 || R_src !== 1'b0 || L0_ack !== 1'b0 ||
            L1_ack !== 1'b0 || xfer_cnt !== '0) begin
            errors++;
            $display("FAIL %s: R_req=%0d R_data=%h R_src=%0d L0_ack=%0d L1_ack=%0d cnt=%0d, required all 0",
                     name, R_req, R_data, R_src, L0_ack, L1_ack, xfer_cnt);
        end
    endtask

    task automatic test_reset();
        #1;
        check_zero_outputs("reset_held");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_released");
    endtask

    task automatic test_single();
        int n = 0;
        ack_dly = 0;
        @(posedge clk);
        sb_q.push_back('{data: 8'hA5, src: 1'b0});
        p0_q.push_back(8'hA5);
        do begin @(posedge clk); n++; end while (!L0_req && n < 50);
        #1;
        checks++;
        if (R_req !== 1'b1 || R_data !== 8'hA5 || R_src !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: R_req=%0d R_data=%h R_src=%0d, required 1 a5 0", R_req, R_data, R_src);
        end
        wait_idle("single");
        check_cnt("single", 1);
    endtask

    task automatic test_rr_pointer();
        @(posedge clk);
        sb_q.push_back('{data: 8'h88, src: 1'b1});
        sb_q.push_back('{data: 8'h77, src: 1'b0});
        p0_q.push_back(8'h77);
        p1_q.push_back(8'h88);
        wait_idle("rr_pointer");
        check_cnt("rr_pointer", 3);
    endtask

    task automatic test_contention();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{data: 8'h11, src: 1'b0});
            sb_q.push_back('{data: 8'h22, src: 1'b1});
            p0_q.push_back(8'h11);
            p1_q.push_back(8'h22);
        end
        wait_idle("contention");
        check_cnt("contention", 10);
    endtask

    task automatic test_lone();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back('{data: 8'h3C, src: 1'b1});
            p1_q.push_back(8'h3C);
        end
        wait_idle("lone");
        check_cnt("lone", 3);
    endtask

    task automatic test_slow_consumer();
        ack_dly = 7;
        @(posedge clk);
        sb_q.push_back('{data: 8'hC3, src: 1'b0});
        sb_q.push_back('{data: 8'hD4, src: 1'b1});
        p0_q.push_back(8'hC3);
        p1_q.push_back(8'hD4);
        wait_idle("slow");
        check_cnt("slow", 5);
        ack_dly = 0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        ack_dly = 7;
        @(posedge clk);
        sb_q.push_back('{data: 8'h5A, src: 1'b0});
        p0_q.push_back(8'h5A);
        do begin @(posedge clk); #1; n++; end while (!R_req && n < 50);
        checks++;
        if (R_data !== 8'h5A) begin
            errors++;
            $display("FAIL reset_mid_pre: R_data=%h, required 5a", R_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero_outputs("reset_mid_abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_idle("reset_mid");
        check_cnt("reset_mid", 1);
        ack_dly = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        @(posedge clk);
        for (int i = 0; i < 17; i++) begin
            sb_q.push_back('{data: W'(i + 8'h40), src: 1'b0});
            p0_q.push_back(W'(i + 8'h40));
        end
        wait_idle("wrap");
        check_cnt("wrap", 1);
    endtask

    initial begin
        rst     = 1'b1;
        L0_req  = 1'b0;
        L1_req  = 1'b0;
        L0_data = '0;
        L1_data = '0;
        test_reset();
        test_single();
        test_rr_pointer();
        test_contention();
        test_lone();
        test_slow_consumer();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
